// File: rtl/axi_w_burst_shaper_if.sv
// Signal bundle around the W-burst shaper: upstream stream, AXI W port and burst-length FIFO.
// The "slave" modport is the shaper's view; "master" is the surrounding environment's view.
interface axi_w_burst_shaper_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] s_axis_w_data;
  logic [STRB_WIDTH-1:0] s_axis_w_keep;
  logic                  s_axis_w_last;
  logic                  s_axis_w_valid;
  logic                  s_axis_w_ready;

  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  logic                  burst_len_fifo_ren;
  logic [7:0]            burst_len_fifo_dout;
  logic                  burst_len_fifo_empty_n;

  modport slave (
    input  s_axis_w_data, s_axis_w_keep, s_axis_w_last, s_axis_w_valid,
    output s_axis_w_ready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    output burst_len_fifo_ren,
    input  burst_len_fifo_dout, burst_len_fifo_empty_n
  );

  modport master (
    output s_axis_w_data, s_axis_w_keep, s_axis_w_last, s_axis_w_valid,
    input  s_axis_w_ready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    input  burst_len_fifo_ren,
    output burst_len_fifo_dout, burst_len_fifo_empty_n
  );
endinterface

// File: rtl/axi_w_burst_shaper.sv
// Cuts an upstream data stream into AXI W bursts whose lengths come from a FWFT FIFO,
// with optional zero-strobe padding on early upstream last and an optional output skid slice.
module axi_w_burst_shaper #(
  parameter int DATA_WIDTH    = 32,
  parameter int EN_OUT_REG    = 0,
  parameter int PAD_EN        = 0,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int SIM_DELAY     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  axi_w_burst_shaper_if.slave      bus,
  output logic                     burst_done,
  output logic                     pad_event,
  output logic [ERR_CNT_WIDTH-1:0] pad_cnt,
  output logic [1:0]               dbg_state
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t state;
  logic [7:0] len_r;
  logic [7:0] cnt;

  // Handshakes: a beat transfers on a rising clk edge where valid and ready are both high;
  // valid never waits on ready, and a presented beat holds steady until it transfers.
  logic                  core_valid;
  logic                  core_ready;
  logic                  core_fire;
  logic [DATA_WIDTH-1:0] core_data;
  logic [STRB_WIDTH-1:0] core_strb;
  logic                  core_last;
  logic                  s_ready;
  logic                  ren;

  always_comb begin
    core_valid = 1'b0;
    core_data  = '0;
    core_strb  = '0;
    core_last  = 1'b0;
    s_ready    = 1'b0;
    ren        = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: ren = bus.burst_len_fifo_empty_n;
        XFER: begin
          core_valid = bus.s_axis_w_valid;
          core_data  = bus.s_axis_w_data;
          core_strb  = bus.s_axis_w_keep;
          core_last  = (cnt == len_r);
          s_ready    = core_ready;
        end
        PAD: begin
          core_valid = 1'b1;
          core_last  = (cnt == len_r);
        end
        default: ;
      endcase
    end
  end

  assign core_fire              = core_valid & core_ready;
  assign bus.s_axis_w_ready     = s_ready;
  assign bus.burst_len_fifo_ren = ren;
  assign dbg_state              = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_r      <= '0;
      cnt        <= '0;
      burst_done <= 1'b0;
      pad_event  <= 1'b0;
      pad_cnt    <= '0;
    end else begin
      burst_done <= 1'b0;
      pad_event  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ren) begin
            len_r <= bus.burst_len_fifo_dout;
            cnt   <= '0;
            state <= XFER;
          end
        end
        XFER, PAD: begin
          if (core_fire) begin
            cnt <= cnt + 8'd1;
            if (core_last) begin
              burst_done <= 1'b1;
              state      <= IDLE;
            end else if (state == XFER && PAD_EN != 0 && bus.s_axis_w_last) begin
              // Upstream ended before the burst did: fill the remainder with null beats.
              pad_event <= 1'b1;
              if (pad_cnt != '1) pad_cnt <= pad_cnt + ERR_CNT_WIDTH'(1);
              state <= PAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if (EN_OUT_REG == 0) begin : g_pass
    assign core_ready       = bus.m_axi_wready;
    assign bus.m_axi_wvalid = core_valid;
    assign bus.m_axi_wdata  = core_data;
    assign bus.m_axi_wstrb  = core_strb;
    assign bus.m_axi_wlast  = core_last;
  end else begin : g_slice
    logic                  out_valid, skd_valid;
    logic [DATA_WIDTH-1:0] out_data, skd_data;
    logic [STRB_WIDTH-1:0] out_strb, skd_strb;
    logic                  out_last, skd_last;
    logic                  push, pop;

    // Ready depends only on the skid flop, so there is no combinational path from wready.
    assign core_ready = ~skd_valid & ~rst;
    assign push       = core_valid & core_ready;
    assign pop        = out_valid & bus.m_axi_wready;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_strb  <= '0;
        out_last  <= 1'b0;
        skd_valid <= 1'b0;
        skd_data  <= '0;
        skd_strb  <= '0;
        skd_last  <= 1'b0;
      end else if (pop || !out_valid) begin
        if (skd_valid) begin
          out_data  <= skd_data;
          out_strb  <= skd_strb;
          out_last  <= skd_last;
          out_valid <= 1'b1;
          skd_valid <= push;
          if (push) begin
            skd_data <= core_data;
            skd_strb <= core_strb;
            skd_last <= core_last;
          end
        end else if (push) begin
          out_data  <= core_data;
          out_strb  <= core_strb;
          out_last  <= core_last;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (push) begin
        skd_data  <= core_data;
        skd_strb  <= core_strb;
        skd_last  <= core_last;
        skd_valid <= 1'b1;
      end
    end

    assign bus.m_axi_wvalid = out_valid;
    assign bus.m_axi_wdata  = out_data;
    assign bus.m_axi_wstrb  = out_strb;
    assign bus.m_axi_wlast  = out_last;
  end
endmodule

// File: tb/tb_axi_w_burst_shaper.sv
// Directed bench for axi_w_burst_shaper: instance A (pass-through, padding, 2-bit pad counter)
// and instance B (skid slice, no padding) share one cycle-stepped driver selected by sel.
module tb_axi_w_burst_shaper;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int BW = 1 + SW + DW;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  axi_w_burst_shaper_if #(.DATA_WIDTH(DW)) if_a ();
  axi_w_burst_shaper_if #(.DATA_WIDTH(DW)) if_b ();

  logic        done_a, pev_a, done_b, pev_b;
  logic [1:0]  pcnt_a, st_a, st_b;
  logic [15:0] pcnt_b;

  axi_w_burst_shaper #(.DATA_WIDTH(DW), .EN_OUT_REG(0), .PAD_EN(1), .ERR_CNT_WIDTH(2)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .burst_done(done_a), .pad_event(pev_a),
    .pad_cnt(pcnt_a), .dbg_state(st_a)
  );
  axi_w_burst_shaper #(.DATA_WIDTH(DW), .EN_OUT_REG(1), .PAD_EN(0), .ERR_CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .burst_done(done_b), .pad_event(pev_b),
    .pad_cnt(pcnt_b), .dbg_state(st_b)
  );

  // Shared drive signals, routed to the selected instance only.
  logic [DW-1:0] drv_data = '0;
  logic [SW-1:0] drv_keep = '0;
  logic          drv_last = 1'b0, drv_valid = 1'b0, drv_wready = 1'b0, drv_empty_n = 1'b0;
  logic [7:0]    drv_dout = '0;
  logic          req_rst = 1'b1, req_sel = 1'b0;

  assign if_a.s_axis_w_data         = drv_data;
  assign if_a.s_axis_w_keep         = drv_keep;
  assign if_a.s_axis_w_last         = drv_last;
  assign if_a.s_axis_w_valid        = drv_valid & ~sel;
  assign if_a.m_axi_wready          = drv_wready & ~sel;
  assign if_a.burst_len_fifo_dout   = drv_dout;
  assign if_a.burst_len_fifo_empty_n = drv_empty_n & ~sel;
  assign if_b.s_axis_w_data         = drv_data;
  assign if_b.s_axis_w_keep         = drv_keep;
  assign if_b.s_axis_w_last         = drv_last;
  assign if_b.s_axis_w_valid        = drv_valid & sel;
  assign if_b.m_axi_wready          = drv_wready & sel;
  assign if_b.burst_len_fifo_dout   = drv_dout;
  assign if_b.burst_len_fifo_empty_n = drv_empty_n & sel;

  logic          obs_s_ready, obs_wvalid, obs_ren, obs_done, obs_pev;
  logic [BW-1:0] obs_beat;
  logic [15:0]   obs_pcnt;
  logic [1:0]    obs_state;
  assign obs_s_ready = sel ? if_b.s_axis_w_ready : if_a.s_axis_w_ready;
  assign obs_wvalid  = sel ? if_b.m_axi_wvalid : if_a.m_axi_wvalid;
  assign obs_ren     = sel ? if_b.burst_len_fifo_ren : if_a.burst_len_fifo_ren;
  assign obs_done    = sel ? done_b : done_a;
  assign obs_pev     = sel ? pev_b : pev_a;
  assign obs_pcnt    = sel ? pcnt_b : {14'd0, pcnt_a};
  assign obs_state   = sel ? st_b : st_a;
  assign obs_beat    = sel ? {if_b.m_axi_wlast, if_b.m_axi_wstrb, if_b.m_axi_wdata}
                           : {if_a.m_axi_wlast, if_a.m_axi_wstrb, if_a.m_axi_wdata};

  // Models and scoreboard
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] up_q[$];
  logic [7:0]    len_q[$];
  int            hs_cyc[$];
  int n_vec = 0, n_err = 0;
  int n_ren = 0, n_done = 0, n_pev = 0, n_beats = 0, n_extra = 0, pad_ready_bad = 0, cyc = 0;
  bit throttle = 1'b0, up_hold = 1'b0, prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  string cur_tag = "init";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_up(input logic [DW-1:0] d, input logic [SW-1:0] k, input logic l);
    up_q.push_back({l, k, d});
  endtask

  task automatic add_exp(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    exp_q.push_back({l, s, d});
  endtask

  task automatic clear_up();
    up_q.delete();
    up_hold = 1'b0;
  endtask

  // One clock: drive at negedge, sample 1ns later, account for handshakes at the next posedge.
  task automatic step();
    logic [BW-1:0] b;
    @(negedge clk);
    rst         = req_rst;
    sel         = req_sel;
    drv_empty_n = (len_q.size() != 0);
    drv_dout    = (len_q.size() != 0) ? len_q[0] : 8'd0;
    if (!up_hold) drv_valid = (up_q.size() != 0) && (!throttle || $urandom_range(0, 3) != 0);
    if (up_q.size() != 0) {drv_last, drv_keep, drv_data} = up_q[0];
    else {drv_last, drv_keep, drv_data} = '0;
    drv_wready = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
    #1;
    if (obs_ren === 1'b1) begin
      n_ren++;
      if (len_q.size() != 0) void'(len_q.pop_front());
    end
    up_hold = drv_valid && (obs_s_ready !== 1'b1);
    if (drv_valid && obs_s_ready === 1'b1 && up_q.size() != 0) void'(up_q.pop_front());
    b = obs_beat;
    if (prev_stall) chk({cur_tag, " w_stable"}, {obs_wvalid, b}, {1'b1, prev_beat});
    if (obs_wvalid === 1'b1 && drv_wready) begin
      hs_cyc.push_back(cyc);
      n_beats++;
      if (exp_q.size() == 0) n_extra++;
      else chk({cur_tag, " w_beat"}, b, exp_q.pop_front());
    end
    prev_stall = (obs_wvalid === 1'b1) && !drv_wready;
    prev_beat  = b;
    if (obs_state == 2'd2 && obs_s_ready === 1'b1) pad_ready_bad++;
    if (obs_done === 1'b1) n_done++;
    if (obs_pev === 1'b1) n_pev++;
    cyc++;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({cur_tag, " drained"}, exp_q.size(), 0);
    step();
    step();
    chk({cur_tag, " extra_beats"}, n_extra, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ren"}, obs_ren, 0);
    chk({tag, " wvalid"}, obs_wvalid, 0);
    chk({tag, " wlast"}, obs_beat[BW-1], 0);
    chk({tag, " s_ready"}, obs_s_ready, 0);
    chk({tag, " done"}, obs_done, 0);
    chk({tag, " pad_event"}, obs_pev, 0);
    chk({tag, " state"}, obs_state, ST_IDLE);
  endtask

  initial begin
    int r0, d0, p0, b0;
    // Reset with a length already waiting: nothing may be popped while rst is high.
    len_q.push_back(8'd3);
    step();
    step();
    chk_quiet("reset");
    chk("reset pad_cnt", obs_pcnt, 0);
    chk("reset len_kept", len_q.size(), 1);

    // Basic 4-beat burst, pass-through
    cur_tag = "t1";
    r0 = n_ren; d0 = n_done;
    add_up(32'hD000_0000, 4'hF, 1'b0); add_up(32'hD000_0001, 4'h3, 1'b0);
    add_up(32'hD000_0002, 4'hC, 1'b0); add_up(32'hD000_0003, 4'h1, 1'b0);
    add_exp(32'hD000_0000, 4'hF, 1'b0); add_exp(32'hD000_0001, 4'h3, 1'b0);
    add_exp(32'hD000_0002, 4'hC, 1'b0); add_exp(32'hD000_0003, 4'h1, 1'b1);
    req_rst = 1'b0;
    run(50);
    chk("t1 ren_pulses", n_ren - r0, 1);
    chk("t1 burst_done", n_done - d0, 1);
    add_up(32'hD000_0004, 4'hF, 1'b0);
    step(); step(); step();
    chk("t1 s_ready_idle", obs_s_ready, 0);
    chk("t1 beat_not_taken", up_q.size(), 1);
    clear_up();

    // Early upstream last on beat 2 of an 8-beat burst
    cur_tag = "t3";
    p0 = n_pev; pad_ready_bad = 0;
    len_q.push_back(8'd7);
    add_up(32'hA0, 4'hF, 1'b0); add_up(32'hA1, 4'hF, 1'b0); add_up(32'hA2, 4'hF, 1'b1);
    add_up(32'hEE, 4'hF, 1'b0);
    add_exp(32'hA0, 4'hF, 1'b0); add_exp(32'hA1, 4'hF, 1'b0); add_exp(32'hA2, 4'hF, 1'b0);
    for (int i = 3; i < 8; i++) add_exp(32'h0, 4'h0, i == 7);
    run(60);
    chk("t3 pad_event", n_pev - p0, 1);
    chk("t3 pad_cnt", obs_pcnt, 1);
    chk("t3 ready_in_pad", pad_ready_bad, 0);
    chk("t3 extra_kept", up_q.size(), 1);
    clear_up();

    // Upstream last on the final beat: no padding
    cur_tag = "t4";
    p0 = n_pev;
    len_q.push_back(8'd5);
    for (int i = 0; i < 6; i++) begin
      add_up(32'hC0 + i, 4'hF, i == 5);
      add_exp(32'hC0 + i, 4'hF, i == 5);
    end
    run(60);
    chk("t4 pad_event", n_pev - p0, 0);
    chk("t4 pad_cnt", obs_pcnt, 1);

    // Four more pad events on 2-beat bursts: 2-bit counter saturates at 3
    cur_tag = "t5";
    p0 = n_pev;
    for (int k = 0; k < 4; k++) begin
      len_q.push_back(8'd1);
      add_up(32'hE0 + k, 4'h5, 1'b1);
      add_exp(32'hE0 + k, 4'h5, 1'b0);
      add_exp(32'h0, 4'h0, 1'b1);
    end
    run(80);
    chk("t5 pad_events", n_pev - p0, 4);
    chk("t5 pad_cnt_sat", obs_pcnt, 3);

    // Reset at beat 4 of a 16-beat burst, then a clean 2-beat burst
    cur_tag = "t6";
    len_q.push_back(8'd15);
    for (int i = 0; i < 16; i++) add_up(32'h6000 + i, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) add_exp(32'h6000 + i, 4'hF, 1'b0);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) step();
    chk("t6 first_beats", exp_q.size(), 0);
    req_rst = 1'b1;
    step();
    step();
    chk_quiet("t6 in_reset");
    chk("t6 pad_cnt", obs_pcnt, 0);
    req_rst = 1'b0;
    step();
    chk_quiet("t6 post_reset");
    clear_up();
    d0 = n_done;
    len_q.push_back(8'd1);
    add_up(32'hB0, 4'hF, 1'b0); add_up(32'hB1, 4'hA, 1'b0);
    add_exp(32'hB0, 4'hF, 1'b0); add_exp(32'hB1, 4'hA, 1'b1);
    run(30);
    chk("t6 restart_done", n_done - d0, 1);

    // Instance B: 1-beat then 256-beat burst under random throttling
    cur_tag = "t7";
    req_sel = 1'b1;
    step();
    throttle = 1'b1;
    d0 = n_done; b0 = n_beats;
    len_q.push_back(8'd0);
    len_q.push_back(8'd255);
    for (int i = 0; i < 257; i++) begin
      logic [3:0] k;
      k = 4'(i);
      add_up(32'h1000 + i, k, i == 100);
      add_exp(32'h1000 + i, k, (i == 0) || (i == 256));
    end
    run(4000);
    chk("t7 bursts_done", n_done - d0, 2);
    chk("t7 beat_count", n_beats - b0, 257);
    throttle = 1'b0;

    // Instance B: two 16-beat bursts at full rate, one idle cycle between
    cur_tag = "t8";
    step();
    hs_cyc.delete();
    len_q.push_back(8'd15);
    len_q.push_back(8'd15);
    for (int i = 0; i < 32; i++) begin
      add_up(32'h8000 + i, 4'hF, 1'b0);
      add_exp(32'h8000 + i, 4'hF, (i == 15) || (i == 31));
    end
    run(200);
    chk("t8 beats", hs_cyc.size(), 32);
    if (hs_cyc.size() == 32) begin
      chk("t8 burst0_span", hs_cyc[15] - hs_cyc[0], 15);
      chk("t8 burst1_span", hs_cyc[31] - hs_cyc[16], 15);
      chk("t8 gap", hs_cyc[16] - hs_cyc[15], 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_w_burst_shaper.md
Name: axi_w_burst_shaper

Overview:
Parametrised AXI write-data (W) channel shaper placed between a stream producer (e.g. frame-buffer write path) and an AXI master W port. For each burst it pops one burst length from the burst-length FIFO and emits exactly that many beats with WLAST on the final one. It supports generic data width, an optional output register slice, and optional zero-strobe padding when the upstream stream ends early. It also reports burst-done and padding-error status.

Parameters:
DATA_WIDTH, 32, W data width; legal values 32/64/128/256; strobe width STRB_WIDTH = DATA_WIDTH/8.
EN_OUT_REG, 0, 1 = registered full-throughput skid slice on the M side; 0 = combinational pass-through.
PAD_EN, 0, 1 = an early upstream last pads the rest of the burst with zero-strobe beats; 0 = s_axis_w_last is ignored.
ERR_CNT_WIDTH, 16, width of the saturating padding-event counter.
SIM_DELAY, 1, simulation-only delay on register assignments.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axis_w_data  in  DATA_WIDTH  upstream data
s_axis_w_keep  in  STRB_WIDTH  upstream byte enables
s_axis_w_last  in  1  upstream end-of-transfer
s_axis_w_valid  in  1  upstream valid
s_axis_w_ready  out  1  upstream ready
m_axi_wdata  out  DATA_WIDTH  AXI W data
m_axi_wstrb  out  STRB_WIDTH  AXI W strobes
m_axi_wlast  out  1  AXI W last
m_axi_wvalid  out  1  AXI W valid
m_axi_wready  in  1  AXI W ready
burst_len_fifo_ren  out  1  pop strobe, first-word-fall-through FIFO
burst_len_fifo_dout  in  8  burst length minus 1
burst_len_fifo_empty_n  in  1  FIFO not empty
burst_done  out  1  one-cycle pulse when the last beat of a burst is accepted at the core output
pad_event  out  1  one-cycle pulse when padding starts
pad_cnt  out  ERR_CNT_WIDTH  saturating count of padding events

Behaviour:
- Reset is synchronous (rst=1 at a clk edge):
  - FSM goes to IDLE; beat counter = 0; pad_cnt = 0.
  - All outputs are 0: valid/ready/ren/last/pulses, and the skid slice is emptied.
  - Reset mid-burst drops the burst and any in-flight beats; no WLAST is emitted for it.
- FSM states IDLE, XFER, PAD.
- IDLE:
  - burst_len_fifo_ren = burst_len_fifo_empty_n (combinational).
  - On a pop: len_r <= dout, cnt <= 0, go to XFER.
  - First beat can be offered the cycle after the pop (1-cycle pop-to-data latency).
  - The FIFO is never read outside IDLE.
- XFER:
  - Core beat: data/keep from upstream; last = (cnt == len_r).
  - Core valid = s_axis_w_valid. s_axis_w_ready = core_ready.
  - On core handshake: cnt <= cnt+1.
    - If last: pulse burst_done; go to IDLE.
    - Else if PAD_EN and s_axis_w_last: pulse pad_event; increment pad_cnt (saturate at all-ones); go to PAD.
  - Upstream last on the burst's final beat, or no upstream last at all, is normal (a frame may span many bursts) and does not pad.
- PAD (PAD_EN=1 only):
  - s_axis_w_ready = 0.
  - Core beat: data = 0, strb = 0, valid = 1, last = (cnt == len_r).
  - Counting is the same as XFER; on the final beat pulse burst_done and go to IDLE.
- Counter: cnt is 8 bits. len_r=0 gives a single-beat burst with last on beat 0. len_r=255 gives 256 beats, and cnt never wraps within a burst.
- Back-to-back bursts: the minimum gap is one idle output cycle between a WLAST handshake and the next burst's first beat (the IDLE pop cycle).
- EN_OUT_REG=0:
  - M outputs equal the core beat.
  - core_ready = m_axi_wready.
  - m_axi_wvalid is combinational from s_axis_w_valid in XFER.
- EN_OUT_REG=1:
  - Two-entry skid slice; all M-side outputs come from flops.
  - core_ready = slice not full, where full means 2 entries.
  - Sustains 1 beat/cycle when m_axi_wready is held high.
  - Adds 1 cycle of latency.
  - burst_done refers to the core handshake, not the M-side one.
  - The FSM may pop the next length while the slice still holds the previous WLAST beat.
- AXI rules:
  - Once m_axi_wvalid is asserted, m_axi_wvalid/wdata/wstrb/wlast stay stable until wready.
  - Data-path width is DATA_WIDTH throughout; keep maps 1:1 to wstrb.

Test Plan:
- Reset, then FIFO holds len-1=3; upstream streams 4 beats (D0..D3) with continuous valid/ready → ren pulses once; 4 W beats; wlast only on D3; burst_done one pulse; s_axis_w_ready=0 afterwards until the next pop.
- FIFO holds {0, 255} with random wready/valid throttling, EN_OUT_REG=1 → a 1-beat burst with wlast, then a 256-beat burst with wlast on beat 255; data order preserved; no beat lost or duplicated; stability under backpressure.
- PAD_EN=1, len-1=7, upstream last on beat 2 → beats 0–2 carry data; beats 3–7 have wdata=0, wstrb=0; wlast on beat 7; pad_event pulses once; pad_cnt=1; upstream ready=0 during PAD.
- PAD_EN=1, upstream last exactly on the final beat of len-1=5 → no pad_event; pad_cnt unchanged.
- EN_OUT_REG=1, wready held 1, two bursts of 16 beats each queued → 16 beats/16 cycles per burst; exactly one idle cycle between the bursts; pad_cnt saturation forced by a preset counter width test (ERR_CNT_WIDTH=2, 5 pad events → pad_cnt=3).
- rst asserted at beat 4 of a 16-beat burst → next cycle all outputs 0 and FSM in IDLE; a new burst from the FIFO starts cleanly with cnt=0.
